// File: rtl/hwpe_mstream_ctrl_pkg.sv
// hwpe_mstream_ctrl_package: shared state enum, default widths and status flags for the stream job controller
package hwpe_mstream_ctrl_package;
  localparam int CNT_W_DEF = 32;
  localparam int TIMEOUT_W_DEF = 16;
  typedef enum logic [2:0] {IDLE, WAIT_READY, START, RUN, FINISHED} state_e;
  typedef struct packed {
    logic busy;
    logic done;
    logic err;
  } flags_t;
endpackage

// File: rtl/hwpe_mstream_ctrl_if.sv
// hwpe_mstream_ctrl_if: streamer/engine handshakes between the job controller (master) and the datapath (slave)
// Signals: in_ready/in_start/in_done per source stream, out_ready/out_start/out_done/out_beat per sink stream,
//   engine_start/engine_done for the engine.
interface hwpe_mstream_ctrl_if #(
  parameter int N_IN = 2,
  parameter int N_OUT = 1
);
  logic [N_IN-1:0] in_ready, in_start, in_done;
  logic [N_OUT-1:0] out_ready, out_start, out_done, out_beat;
  logic engine_start, engine_done;
  modport master (
    input in_ready, in_done, out_ready, out_done, out_beat, engine_done,
    output in_start, out_start, engine_start
  );
  modport slave (
    output in_ready, in_done, out_ready, out_done, out_beat, engine_done,
    input in_start, out_start, engine_start
  );
endinterface

// File: rtl/hwpe_mstream_ctrl_beat_cnt.sv
// hwpe_mstream_beat_cnt: saturating beat counter that stops at limit_i and flags it on reached_o
// Ports: clk_i/rst_ni (async active-low), clear_i sync clear, en_i count enable, limit_i saturation value,
//   cnt_o current count, reached_o count equals limit_i.
module hwpe_mstream_beat_cnt
  import hwpe_mstream_ctrl_package::*;
#(
  parameter int CNT_W = CNT_W_DEF
)(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [CNT_W:0]   limit_i,
  output logic [CNT_W:0]   cnt_o,
  output logic             reached_o
);
  logic [CNT_W:0] r_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_cnt <= '0;
    else if (clear_i) r_cnt <= '0;
    else if (en_i && !reached_o) r_cnt <= r_cnt + 1'b1;
  assign reached_o = r_cnt == limit_i;
  assign cnt_o = r_cnt;
endmodule

// File: rtl/hwpe_mstream_ctrl.sv
// hwpe_mstream_ctrl: N_IN/N_OUT job sequencer that launches streamers and engine, then signals done once all finish
// Ports: clk_i/rst_ni (async active-low), clear_i soft clear, trigger_i job start, cnt_limit_i beats-1 per sink,
//   strm streamer/engine handshakes, busy_o/done_o/evt_o status, cnt_o channel-0 beat count, err_o sticky timeout.
// Optional watchdog enabled by defining HWPE_MSTREAM_CTRL_TIMEOUT_EN.
module hwpe_mstream_ctrl
  import hwpe_mstream_ctrl_package::*;
#(
  parameter int N_IN = 2,
  parameter int N_OUT = 1,
  parameter int N_CORES = 2,
  parameter int CNT_W = CNT_W_DEF,
  parameter int TIMEOUT_W = TIMEOUT_W_DEF
)(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               trigger_i,
  input  logic [CNT_W-1:0]   cnt_limit_i,
  hwpe_mstream_ctrl_if.master strm,
  output logic               busy_o,
  output logic               done_o,
  output logic [N_CORES-1:0] evt_o,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               err_o
);
  state_e r_state, w_state_nxt;
  logic [CNT_W-1:0] r_limit;
  logic [N_IN-1:0] r_in_done;
  logic [N_OUT-1:0] r_out_done, w_reached;
  logic r_eng_done;
  logic [CNT_W:0] w_lim1;
  logic [N_OUT*(CNT_W+1)-1:0] w_cnt;
  logic w_go, w_all_done, w_timeout, w_err, w_unused;
  flags_t w_flags;
  assign w_go = r_state == IDLE && trigger_i;
  // one extra bit so a limit of all-ones still yields a reachable target
  assign w_lim1 = {1'b0, r_limit} + 1'b1;
  assign w_all_done = &w_reached && &r_in_done && &r_out_done && r_eng_done;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) r_state <= IDLE;
    else r_state <= clear_i ? IDLE : w_state_nxt;
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       w_state_nxt = trigger_i ? WAIT_READY : IDLE;
      WAIT_READY: w_state_nxt = &strm.in_ready && &strm.out_ready ? START : WAIT_READY;
      START:      w_state_nxt = RUN;
      RUN:        w_state_nxt = w_all_done || w_timeout ? FINISHED : RUN;
      FINISHED:   w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_limit <= '0;
      r_in_done <= '0;
      r_out_done <= '0;
      r_eng_done <= 1'b0;
    end else if (clear_i) begin
      r_limit <= '0;
      r_in_done <= '0;
      r_out_done <= '0;
      r_eng_done <= 1'b0;
    end else if (w_go) begin
      r_limit <= cnt_limit_i;
      r_in_done <= '0;
      r_out_done <= '0;
      r_eng_done <= 1'b0;
    end else if (r_state == RUN) begin
      r_in_done <= r_in_done | strm.in_done;
      r_out_done <= r_out_done | strm.out_done;
      r_eng_done <= r_eng_done | strm.engine_done;
    end
  for (genvar k = 0; k < N_OUT; k++) begin : g_cnt
    hwpe_mstream_beat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i || w_go),
      .en_i      (r_state == RUN && strm.out_beat[k]),
      .limit_i   (w_lim1),
      .cnt_o     (w_cnt[k*(CNT_W+1) +: CNT_W+1]),
      .reached_o (w_reached[k])
    );
  end
  // only channel 0 is exported; the rest feed completion through reached_o
  assign w_unused = ^w_cnt[N_OUT*(CNT_W+1)-1:CNT_W];
`ifdef HWPE_MSTREAM_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_wdog, w_wdog_nxt;
  logic r_err, w_act;
  assign w_act = |strm.out_beat || |strm.in_done || |strm.out_done || strm.engine_done;
  assign w_wdog_nxt = w_act ? '0 : r_wdog + 1'b1;
  assign w_timeout = r_state == RUN && &w_wdog_nxt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      r_wdog <= '0;
      r_err <= 1'b0;
    end else if (clear_i) begin
      r_wdog <= '0;
      r_err <= 1'b0;
    end else begin
      r_wdog <= r_state == RUN ? w_wdog_nxt : '0;
      r_err <= w_go ? 1'b0 : r_err || w_timeout;
    end
  assign w_err = r_err;
`else
  localparam int unused_timeout_w = TIMEOUT_W;
  assign w_timeout = 1'b0;
  assign w_err = 1'b0;
`endif
  assign w_flags = {r_state != IDLE, r_state == FINISHED, w_err};
  assign strm.in_start = {N_IN{r_state == START}};
  assign strm.out_start = {N_OUT{r_state == START}};
  assign strm.engine_start = r_state == START;
  assign busy_o = w_flags.busy;
  assign done_o = w_flags.done;
  assign err_o = w_flags.err;
  assign evt_o = {N_CORES{w_flags.done}};
  assign cnt_o = w_cnt[CNT_W-1:0];
endmodule
